// File: rtl/servo_pwm_adc_pkg.sv
// Shared constants for the servo PWM stage fed by the ADC capture path.
// Latency: n/a; backpressure: n/a (definitions only).
package servo_pwm_adc_pkg;

  localparam int unsigned PERIODO_DEF   = 2000000;
  localparam int unsigned PULSO_MIN_DEF = 100000;
  localparam int unsigned PASO_DEF      = 24;
  localparam int unsigned PULSO_MAX_DEF = 200000;
  localparam int unsigned CNT_W_DEF     = 21;

  localparam int unsigned MUESTRA_W  = 12;
  localparam int unsigned SUMA_W     = 14;
  localparam int unsigned N_MUESTRAS = 4;

  typedef logic [MUESTRA_W-1:0] muestra_t;
  typedef logic [SUMA_W-1:0]    suma_t;

endpackage

// File: rtl/servo_pwm_adc_if.sv
// Sample-in / PWM-out bundle between the ADC capture side and the servo stage.
// Latency: n/a; backpressure: none, samples are strobed in by done edges.
interface servo_pwm_adc_if #(
  parameter int unsigned CNT_W = servo_pwm_adc_pkg::CNT_W_DEF
);
  import servo_pwm_adc_pkg::*;

  muestra_t          Dato;
  logic              done;
  logic              enable;
  logic              PWM;
  muestra_t          Promedio;
  logic [CNT_W-1:0]  Ancho;
  logic              inicio_periodo;

  modport master (
    output Dato, done, enable,
    input  PWM, Promedio, Ancho, inicio_periodo
  );

  modport slave (
    input  Dato, done, enable,
    output PWM, Promedio, Ancho, inicio_periodo
  );

endinterface

// File: rtl/servo_pwm_adc_sync.sv
// 2-FF synchroniser plus rising-edge detector: one-cycle pulse per input assertion.
// Latency: pulse 2 cycles after the input is first sampled; backpressure: none.
module sincronizador_flanco (
  input  logic Clock_Nexys,
  input  logic Reset,
  input  logic d_in,
  output logic pulso
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = d_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge Clock_Nexys or negedge Reset) begin
    if (!Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign pulso = s2_q & ~s3_q;

endmodule

// File: rtl/servo_pwm_adc.sv
// Averages synchronised ADC samples over 4 and drives a servo PWM whose width follows the average.
// Latency: done rise to Promedio 5 cycles, width applied at next period start; backpressure: none.
module servo_pwm_adc
  import servo_pwm_adc_pkg::*;
#(
  parameter int unsigned PERIODO   = PERIODO_DEF,
  parameter int unsigned PULSO_MIN = PULSO_MIN_DEF,
  parameter int unsigned PASO      = PASO_DEF,
  parameter int unsigned PULSO_MAX = PULSO_MAX_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic            Clock_Nexys,
  input  logic            Reset,
  servo_pwm_adc_if.slave  bus
);

  localparam int unsigned EXT_W = CNT_W + 2;

  logic strobe;

  muestra_t         muestra_q, muestra_d;
  logic             muestra_vld_q, muestra_vld_d;
  muestra_t         hist_q [N_MUESTRAS];
  muestra_t         hist_d [N_MUESTRAS];
  logic [1:0]       ptr_q, ptr_d;
  suma_t            suma_q, suma_d;
  muestra_t         prom_q, prom_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ancho_q, ancho_d;
  logic             pwm_q, pwm_d;
  logic             inicio_q, inicio_d;
  logic [EXT_W-1:0] ancho_ext;

  sincronizador_flanco u_sync (
    .Clock_Nexys (Clock_Nexys),
    .Reset       (Reset),
    .d_in        (bus.done),
    .pulso       (strobe)
  );

  always_comb begin
    muestra_d     = muestra_q;
    muestra_vld_d = strobe;
    hist_d        = hist_q;
    ptr_d         = ptr_q;
    suma_d        = suma_q;
    cnt_d         = cnt_q;
    ancho_d       = ancho_q;
    pwm_d         = 1'b0;
    inicio_d      = 1'b0;

    if (strobe) begin
      muestra_d = bus.Dato;
    end

    // Running sum: swap the oldest sample for the new one; the mod-2^14 result is always in range.
    if (muestra_vld_q) begin
      suma_d         = suma_q + SUMA_W'(muestra_q) - SUMA_W'(hist_q[ptr_q]);
      hist_d[ptr_q]  = muestra_q;
      ptr_d          = ptr_q + 2'd1;
    end

    prom_d = suma_q[SUMA_W-1:2];

    ancho_ext = EXT_W'(PULSO_MIN) + EXT_W'(prom_q) * EXT_W'(PASO);
    pend_d    = (ancho_ext > EXT_W'(PULSO_MAX)) ? CNT_W'(PULSO_MAX) : ancho_ext[CNT_W-1:0];

    if (bus.enable) begin
      cnt_d = (cnt_q == CNT_W'(PERIODO - 1)) ? '0 : cnt_q + 1'b1;
      if (cnt_q == '0) begin
        ancho_d  = pend_q;
        inicio_d = 1'b1;
      end
      // Compare against the width being loaded so the first cycle of a period already uses it.
      pwm_d = (cnt_q < ancho_d);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clock_Nexys or negedge Reset) begin
    if (!Reset) begin
      muestra_q     <= '0;
      muestra_vld_q <= 1'b0;
      for (int i = 0; i < N_MUESTRAS; i++) begin
        hist_q[i] <= '0;
      end
      ptr_q    <= '0;
      suma_q   <= '0;
      prom_q   <= '0;
      pend_q   <= CNT_W'(PULSO_MIN);
      cnt_q    <= '0;
      ancho_q  <= CNT_W'(PULSO_MIN);
      pwm_q    <= 1'b0;
      inicio_q <= 1'b0;
    end else begin
      muestra_q     <= muestra_d;
      muestra_vld_q <= muestra_vld_d;
      hist_q        <= hist_d;
      ptr_q         <= ptr_d;
      suma_q        <= suma_d;
      prom_q        <= prom_d;
      pend_q        <= pend_d;
      cnt_q         <= cnt_d;
      ancho_q       <= ancho_d;
      pwm_q         <= pwm_d;
      inicio_q      <= inicio_d;
    end
  end

  assign bus.PWM            = pwm_q;
  assign bus.Promedio       = prom_q;
  assign bus.Ancho          = ancho_q;
  assign bus.inicio_periodo = inicio_q;

endmodule

// File: tb/tb_servo_pwm_adc.sv
// Bench for servo_pwm_adc: two instances (PASO=2 and PASO=4) share stimulus and are
// compared every cycle against a sample-queue / period-phase model plus literal expectations.
module tb_servo_pwm_adc;
  import servo_pwm_adc_pkg::*;

  localparam int PER  = 10500;
  localparam int PMIN = 1000;
  localparam int PMAX = 10000;
  localparam int CW   = 21;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] dato;
  logic        done;
  logic        en;

  always #5 clk = ~clk;

  servo_pwm_adc_if #(.CNT_W(CW)) if_a ();
  servo_pwm_adc_if #(.CNT_W(CW)) if_b ();

  assign if_a.Dato   = dato;
  assign if_a.done   = done;
  assign if_a.enable = en;
  assign if_b.Dato   = dato;
  assign if_b.done   = done;
  assign if_b.enable = en;

  servo_pwm_adc #(.PERIODO(PER), .PULSO_MIN(PMIN), .PASO(2), .PULSO_MAX(PMAX), .CNT_W(CW)) u_a (
    .Clock_Nexys (clk),
    .Reset       (rst_n),
    .bus         (if_a)
  );

  servo_pwm_adc #(.PERIODO(PER), .PULSO_MIN(PMIN), .PASO(4), .PULSO_MAX(PMAX), .CNT_W(CW)) u_b (
    .Clock_Nexys (clk),
    .Reset       (rst_n),
    .bus         (if_b)
  );

  int tests = 0;
  int fails = 0;

  // Inputs as seen by the active clock edge.
  logic        smp_rst, smp_done, smp_en;
  logic [11:0] smp_dato;

  // Model state.
  int q_hist[$];
  int ev_due[$];
  int ev_val[$];
  int edge_n;
  int done_prev;
  int m_prom;
  int prom_d1;
  int phase;
  int m_ancho[2];
  bit m_pwm[2];
  bit m_ini;

  // Period measurement.
  int hi_cnt[2]  = '{0, 0};
  int last_hi[2] = '{0, 0};
  int len_cnt  = 0;
  int last_len = 0;

  function automatic int paso_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic int width_of(input int prom, input int paso);
    int v;
    v = PMIN + prom * paso;
    return (v > PMAX) ? PMAX : v;
  endfunction

  task automatic model_reset();
    q_hist = '{0, 0, 0, 0};
    ev_due.delete();
    ev_val.delete();
    edge_n    = 0;
    done_prev = 0;
    m_prom    = 0;
    prom_d1   = 0;
    phase     = 0;
    m_ini     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_ancho[i] = PMIN;
      m_pwm[i]   = 1'b0;
    end
  endtask

  task automatic model_step();
    int w_src;
    int s;
    edge_n++;
    w_src   = prom_d1;
    prom_d1 = m_prom;
    // A done rise seen at this edge shows up as a new average four edges later.
    if (smp_done && done_prev == 0) begin
      ev_due.push_back(edge_n + 4);
      ev_val.push_back(int'(smp_dato));
    end
    done_prev = int'(smp_done);
    while (ev_due.size() > 0 && ev_due[0] == edge_n) begin
      void'(ev_due.pop_front());
      q_hist.push_back(ev_val.pop_front());
      void'(q_hist.pop_front());
      s = 0;
      foreach (q_hist[j]) s += q_hist[j];
      m_prom = s / 4;
    end
    if (smp_en) begin
      for (int i = 0; i < 2; i++) begin
        if (phase == 0) m_ancho[i] = width_of(w_src, paso_of(i));
        m_pwm[i] = (phase < m_ancho[i]);
      end
      m_ini = (phase == 0);
      phase = (phase + 1) % PER;
    end else begin
      phase = 0;
      m_ini = 1'b0;
      m_pwm[0] = 1'b0;
      m_pwm[1] = 1'b0;
    end
  endtask

  task automatic compare(input int i);
    logic          pwm_g, ini_g;
    logic [CW-1:0] anc_g;
    logic [11:0]   prom_g;
    if (i == 0) begin
      pwm_g = if_a.PWM; ini_g = if_a.inicio_periodo; anc_g = if_a.Ancho; prom_g = if_a.Promedio;
    end else begin
      pwm_g = if_b.PWM; ini_g = if_b.inicio_periodo; anc_g = if_b.Ancho; prom_g = if_b.Promedio;
    end
    tests++;
    if (pwm_g !== m_pwm[i] || ini_g !== m_ini || anc_g !== CW'(m_ancho[i]) || prom_g !== 12'(m_prom)) begin
      fails++;
      $display("FAIL cycle_dut%0d t=%0t got pwm=%0b ini=%0b ancho=%0d prom=%0d want pwm=%0b ini=%0b ancho=%0d prom=%0d",
               i, $time, pwm_g, ini_g, anc_g, prom_g, m_pwm[i], m_ini, m_ancho[i], m_prom);
    end
  endtask

  always @(posedge clk) begin
    smp_rst  = rst_n;
    smp_done = done;
    smp_en   = en;
    smp_dato = dato;
  end

  always @(negedge clk) begin
    if (!rst_n || !smp_rst) model_reset();
    else model_step();
    compare(0);
    compare(1);
    if (if_a.inicio_periodo) begin
      last_len = len_cnt;
      len_cnt  = 1;
      last_hi[0] = hi_cnt[0];
      last_hi[1] = hi_cnt[1];
      hi_cnt[0]  = int'(if_a.PWM);
      hi_cnt[1]  = int'(if_b.PWM);
    end else begin
      len_cnt++;
      hi_cnt[0] += int'(if_a.PWM);
      hi_cnt[1] += int'(if_b.PWM);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_inicio();
    int n;
    bit seen;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      seen = if_a.inicio_periodo;
    end while (!seen && n < 2 * PER);
    #1;
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL wait_inicio timeout got=%0d cycles want=inicio pulse", n);
    end
  endtask

  task automatic send_done(input logic [11:0] v);
    @(posedge clk);
    #1 dato = v;
    done = 1'b1;
    repeat (8) @(posedge clk);
    #1 done = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  int t2_exp[4] = '{1023, 2047, 3071, 4095};
  int t3_smp[4] = '{0, 4095, 0, 4095};

  initial begin
    rst_n = 1'b0;
    done  = 1'b0;
    dato  = '0;
    en    = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state and the idle period.
    @(negedge clk);
    check("rst_prom", if_a.Promedio, 0);
    check("rst_ancho", if_a.Ancho, 1000);
    check("rst_pwm", if_a.PWM, 0);
    check("rst_ini", if_a.inicio_periodo, 0);
    wait_inicio();
    wait_inicio();
    check("idle_hi", last_hi[0], 1000);
    check("idle_len", last_len, PER);

    // Full-scale samples ramp the average; PASO=4 instance saturates.
    for (int i = 0; i < 4; i++) begin
      send_done(12'd4095);
      @(negedge clk);
      check($sformatf("ramp_prom%0d", i), if_a.Promedio, t2_exp[i]);
      check($sformatf("ramp_prom_b%0d", i), if_b.Promedio, t2_exp[i]);
    end
    wait_inicio();
    check("full_ancho", if_a.Ancho, 9190);
    check("clamp_ancho_b", if_b.Ancho, 10000);
    wait_inicio();
    check("full_hi", last_hi[0], 9190);
    check("clamp_hi_b", last_hi[1], 10000);

    // Alternating samples arrive during the 9190-cycle pulse.
    for (int i = 0; i < 4; i++) send_done(12'(t3_smp[i]));
    @(negedge clk);
    check("alt_prom", if_a.Promedio, 2047);
    wait_inicio();
    check("midpulse_hi", last_hi[0], 9190);
    check("alt_ancho", if_a.Ancho, 5094);
    check("alt_ancho_b", if_b.Ancho, 9188);

    // Reset mid-pulse.
    repeat (20) @(posedge clk);
    #1 check("pre_rst_pwm", if_a.PWM, 1);
    rst_n = 1'b0;
    #1 check("rst_async_pwm", if_a.PWM, 0);
    check("rst_async_prom", if_a.Promedio, 0);
    check("rst_async_ancho", if_a.Ancho, 1000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ancho", if_a.Ancho, 1000);

    // done held high for a long time: one sample only.
    @(posedge clk);
    #1 dato = 12'd100;
    done = 1'b1;
    repeat (5000) @(posedge clk);
    #1 done = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("held_prom", if_a.Promedio, 25);

    // enable dropped mid-pulse, then restored.
    wait_inicio();
    repeat (100) @(posedge clk);
    #1 check("pre_en_pwm", if_a.PWM, 1);
    en = 1'b0;
    @(posedge clk);
    #1 check("en_off_pwm", if_a.PWM, 0);
    check("en_off_ini", if_a.inicio_periodo, 0);
    repeat (50) @(posedge clk);
    #1 check("en_hold_pwm", if_a.PWM, 0);
    en = 1'b1;
    @(posedge clk);
    #1 check("en_on_ini", if_a.inicio_periodo, 1);
    check("en_on_pwm", if_a.PWM, 1);
    check("en_on_ancho", if_a.Ancho, 1050);
    @(negedge clk);
    wait_inicio();
    check("en_on_len", last_len, PER);
    check("en_on_hi", last_hi[0], 1050);
    check("en_on_hi_b", last_hi[1], 1100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
